mem_stage_sram: RTL and testbench
=================================

Name: mem_stage_sram

Overview:
- Memory stage of the ARM pipeline; sits directly downstream of the EXE stage register.
- Consumes the registered ALU result, store value, memory read/write enables, writeback enable and destination register.
- Performs data-memory access against an internal word array, with a wait-state FSM emulating SRAM latency.
- Drives a ready flag that freezes the upstream pipeline while an access is in flight, and presents load data and pass-through control to the MEM stage register.

Parameters:
DEPTH, 64, number of 32-bit words in the data memory (power of two)
BASE_ADDR, 1024, byte address mapped to word 0
WAIT_CYCLES, 3, SRAM wait states per access (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
WB_en_IN  in  1  writeback enable from EXE stage register
MEM_R_EN_IN  in  1  load request
MEM_W_EN_IN  in  1  store request
ALU_result_IN  in  32  effective byte address / ALU value
ST_val_IN  in  32  store data
Dest_IN  in  4  destination register index
WB_en  out  1  = WB_en_IN (combinational pass-through)
MEM_R_EN  out  1  = MEM_R_EN_IN
ALU_result  out  32  = ALU_result_IN
Dest  out  4  = Dest_IN
MEM_result  out  32  registered load data
ready  out  1  1 = stage may advance; 0 = freeze upstream stages and EXE stage register

Behaviour:
- Request: req = MEM_R_EN_IN | MEM_W_EN_IN. If both are high, it is a write; the read is ignored.
- Word index: (ALU_result_IN - BASE_ADDR) >> 2, truncated to log2(DEPTH) bits; wraps modulo DEPTH. Low two address bits are ignored.
- FSM states:
  - IDLE: if req, load wait counter with WAIT_CYCLES and go to WAIT; else stay.
  - WAIT: decrement counter each cycle; when counter==1, go to DONE. WAIT therefore lasts exactly WAIT_CYCLES cycles.
  - DONE: unconditionally return to IDLE.
- Commit edge: on the WAIT->DONE edge:
  - a write stores ST_val_IN into mem[index];
  - a read loads mem[index] into MEM_result;
  - a write leaves MEM_result unchanged.
- ready (combinational):
  - 0 in IDLE with req, and throughout WAIT;
  - 1 in DONE, and in IDLE without req.
- Latency: request first visible in cycle T (IDLE) -> DONE in cycle T+WAIT_CYCLES+1. Upstream freeze lasts WAIT_CYCLES+1 cycles.
- Sequencing: upstream advances at the end of the DONE cycle. A back-to-back request is seen in IDLE the next cycle, giving one new access per WAIT_CYCLES+2 cycles. Inputs must stay stable while ready=0; the upstream freeze guarantees this.
- Read-after-write to the same word in consecutive accesses returns the new data.
- Reset (async, any state, including mid-WAIT):
  - state=IDLE, counter=0, MEM_result=0;
  - any in-flight write is discarded;
  - memory array contents are not reset;
  - ready is 1 immediately unless req is high.
- Non-memory instructions (req=0) pass through with zero added latency.

Optional Feature:
Macro MEM_ADDR_CHECK_EN.
- Defined:
  - adds output mem_fault (1 bit, registered, reset 0);
  - an access whose address has low bits != 00, is below BASE_ADDR, or is at/above BASE_ADDR+4*DEPTH sets mem_fault=1 on the commit edge;
  - a faulting write does not modify memory; a faulting read sets MEM_result=0;
  - mem_fault clears on the next commit of a valid access;
  - FSM timing is unchanged.
- Not defined: no mem_fault port; addresses wrap silently as above.

Test Plan:
- Reset, then idle with req=0 -> ready=1, MEM_result=0, pass-through outputs follow inputs in the same cycle.
- Store ST_val=0xDEADBEEF to addr 1024, WAIT_CYCLES=3 -> ready=0 for cycles T..T+3, ready=1 at T+4; then load addr 1024 -> MEM_result=0xDEADBEEF in the DONE cycle.
- Stores to addr 1028 (0x11111111) and 1032 (0x22222222), then loads of both -> 0x11111111 and 0x22222222; addr 1024+4*DEPTH wraps to word 0 (macro off).
- Both MEM_R_EN and MEM_W_EN high at addr 1036 with ST_val=0x55 -> treated as write; subsequent load of 1036 returns 0x55.
- Assert rst during WAIT of a store of 0xCAFEF00D to 1040 -> immediate IDLE, ready=1 (req low), MEM_result=0; later load of 1040 does not return 0xCAFEF00D.
- With MEM_ADDR_CHECK_EN: store to addr 1026 -> mem_fault=1, memory unchanged; next valid load -> mem_fault=0.

Source files
------------

// File: rtl/mem_stage_sram.sv
// Memory stage with an internal word array and a wait-state FSM emulating SRAM latency.
// Optional MEM_ADDR_CHECK_EN adds a registered mem_fault flag for misaligned/out-of-range accesses.
module mem_stage_sram #(
  parameter int          DEPTH       = 64,
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int          WAIT_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        WB_en_IN,
  input  logic        MEM_R_EN_IN,
  input  logic        MEM_W_EN_IN,
  input  logic [31:0] ALU_result_IN,
  input  logic [31:0] ST_val_IN,
  input  logic [3:0]  Dest_IN,
  output logic        WB_en,
  output logic        MEM_R_EN,
  output logic [31:0] ALU_result,
  output logic [3:0]  Dest,
  output logic [31:0] MEM_result,
`ifdef MEM_ADDR_CHECK_EN
  output logic        mem_fault,
`endif
  output logic        ready
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(WAIT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [31:0]   mem [DEPTH];
  logic [IW-1:0] idx;
  logic          req;
  logic          is_wr;
  logic          commit;
  logic          ok;

  assign WB_en      = WB_en_IN;
  assign MEM_R_EN   = MEM_R_EN_IN;
  assign ALU_result = ALU_result_IN;
  assign Dest       = Dest_IN;

  assign req    = MEM_R_EN_IN | MEM_W_EN_IN;
  assign is_wr  = MEM_W_EN_IN;
  assign idx    = IW'((ALU_result_IN - BASE_ADDR) >> 2);
  assign commit = (state == WAIT) && (cnt == CW'(1));
  assign ready  = (state == DONE) || ((state == IDLE) && !req);

`ifdef MEM_ADDR_CHECK_EN
  assign ok = (ALU_result_IN[1:0] == 2'b00)
           && (ALU_result_IN >= BASE_ADDR)
           && (ALU_result_IN < BASE_ADDR + 32'(4 * DEPTH));
`else
  assign ok = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      MEM_result <= '0;
`ifdef MEM_ADDR_CHECK_EN
      mem_fault  <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (req) begin
            cnt   <= CW'(WAIT_CYCLES);
            state <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - CW'(1);
          if (commit) begin
            state <= DONE;
            if (!is_wr)
              MEM_result <= ok ? mem[idx] : 32'd0;
`ifdef MEM_ADDR_CHECK_EN
            mem_fault <= !ok;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Array is not reset; rst gating drops a write landing on the reset edge.
  always_ff @(posedge clk) begin
    if (!rst && commit && is_wr && ok)
      mem[idx] <= ST_val_IN;
  end

endmodule

// File: tb/tb_mem_stage_sram.sv
// Scoreboard bench for mem_stage_sram: model memory, latency and result checks.
// Also exercises MEM_ADDR_CHECK_EN when that macro is defined.
module tb_mem_stage_sram;

  localparam int WC = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        WB_en_IN;
  logic        MEM_R_EN_IN;
  logic        MEM_W_EN_IN;
  logic [31:0] ALU_result_IN;
  logic [31:0] ST_val_IN;
  logic [3:0]  Dest_IN;
  logic        WB_en;
  logic        MEM_R_EN;
  logic [31:0] ALU_result;
  logic [3:0]  Dest;
  logic [31:0] MEM_result;
  logic        ready;
`ifdef MEM_ADDR_CHECK_EN
  logic        mem_fault;
`endif

  mem_stage_sram #(
    .DEPTH(64),
    .BASE_ADDR(32'd1024),
    .WAIT_CYCLES(WC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .WB_en_IN(WB_en_IN),
    .MEM_R_EN_IN(MEM_R_EN_IN),
    .MEM_W_EN_IN(MEM_W_EN_IN),
    .ALU_result_IN(ALU_result_IN),
    .ST_val_IN(ST_val_IN),
    .Dest_IN(Dest_IN),
    .WB_en(WB_en),
    .MEM_R_EN(MEM_R_EN),
    .ALU_result(ALU_result),
    .Dest(Dest),
    .MEM_result(MEM_result),
`ifdef MEM_ADDR_CHECK_EN
    .mem_fault(mem_fault),
`endif
    .ready(ready)
  );

  always #5 clk = ~clk;

  int          n_run = 0;
  int          n_fail = 0;
  logic [31:0] mdl [64];
  logic [31:0] exp_res = 32'd0;
  logic [31:0] q_res[$];
  logic        q_flt[$];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic access(input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] val);
    logic [5:0]  i;
    logic [31:0] off;
    logic        bad;
    int          n;
    off = addr - 32'd1024;
    i   = off[7:2];
`ifdef MEM_ADDR_CHECK_EN
    bad = (addr[1:0] != 2'b00) || (addr < 32'd1024) || (addr >= 32'd1280);
`else
    bad = 1'b0;
`endif
    if (wr) begin
      if (!bad) mdl[i] = val;
    end else begin
      exp_res = bad ? 32'd0 : mdl[i];
    end
    q_res.push_back(exp_res);
    q_flt.push_back(bad);
    MEM_R_EN_IN   = rd;
    MEM_W_EN_IN   = wr;
    ALU_result_IN = addr;
    ST_val_IN     = val;
    Dest_IN       = 4'($urandom_range(0, 15));
    #1;
    n = 0;
    while (!ready && n < 20) begin
      n++;
      @(posedge clk);
      #1;
    end
    chk("latency", 32'(n), 32'(WC + 1));
    chk("mem_result", MEM_result, q_res.pop_front());
`ifdef MEM_ADDR_CHECK_EN
    chk("mem_fault", {31'd0, mem_fault}, {31'd0, q_flt.pop_front()});
`else
    void'(q_flt.pop_front());
`endif
    @(posedge clk);
    #1;
    MEM_R_EN_IN = 1'b0;
    MEM_W_EN_IN = 1'b0;
    #1;
    chk("ready_idle", {31'd0, ready}, 32'd1);
  endtask

  initial begin
    rst           = 1'b1;
    WB_en_IN      = 1'b0;
    MEM_R_EN_IN   = 1'b0;
    MEM_W_EN_IN   = 1'b0;
    ALU_result_IN = 32'd0;
    ST_val_IN     = 32'd0;
    Dest_IN       = 4'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_result", MEM_result, 32'd0);
`ifdef MEM_ADDR_CHECK_EN
    chk("rst_fault", {31'd0, mem_fault}, 32'd0);
`endif

    for (int k = 0; k < 3; k++) begin
      logic [31:0] a;
      logic [3:0]  d;
      logic        w;
      a = $urandom;
      d = 4'($urandom_range(0, 15));
      w = 1'($urandom_range(0, 1));
      ALU_result_IN = a;
      Dest_IN       = d;
      WB_en_IN      = w;
      #1;
      chk("pt_alu", ALU_result, a);
      chk("pt_dest", {28'd0, Dest}, {28'd0, d});
      chk("pt_wb", {31'd0, WB_en}, {31'd0, w});
      chk("pt_rd", {31'd0, MEM_R_EN}, 32'd0);
      chk("pt_ready", {31'd0, ready}, 32'd1);
      @(posedge clk);
      #1;
    end

    access(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF);
    access(1'b1, 1'b0, 32'd1024, 32'd0);
    access(1'b0, 1'b1, 32'd1028, 32'h11111111);
    access(1'b0, 1'b1, 32'd1032, 32'h22222222);
    access(1'b1, 1'b0, 32'd1028, 32'd0);
    access(1'b1, 1'b0, 32'd1032, 32'd0);
    access(1'b0, 1'b1, 32'd1280, 32'hA5A5A5A5);
    access(1'b1, 1'b0, 32'd1024, 32'd0);
    access(1'b1, 1'b0, 32'd1280, 32'd0);
    access(1'b1, 1'b1, 32'd1036, 32'h00000055);
    access(1'b1, 1'b0, 32'd1036, 32'd0);
    access(1'b0, 1'b1, 32'd1040, 32'h12345678);

    // store interrupted by reset mid-wait must leave memory untouched
    MEM_W_EN_IN   = 1'b1;
    ALU_result_IN = 32'd1040;
    ST_val_IN     = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("wait_ready", {31'd0, ready}, 32'd0);
    rst         = 1'b1;
    MEM_W_EN_IN = 1'b0;
    #1;
    chk("arst_ready", {31'd0, ready}, 32'd1);
    chk("arst_result", MEM_result, 32'd0);
    exp_res = 32'd0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    access(1'b1, 1'b0, 32'd1040, 32'd0);

    access(1'b0, 1'b1, 32'd1026, 32'h0BADF00D);
    access(1'b1, 1'b0, 32'd1024, 32'd0);
    access(1'b1, 1'b0, 32'd1000, 32'd0);
    access(1'b1, 1'b0, 32'd1028, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
